// File: rtl/aes_host_driver_if.sv
// aes_host_driver_if: bundles the parallel host request/response port and the
// byte-serial AES engine bus seen by aes_host_driver.
interface aes_host_driver_if;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_pt;
    logic [127:0] req_key;
    logic         req_key_load;
    logic [1:0]   aes_cmd;
    logic [7:0]   aes_din;
    logic         aes_ready;
    logic [7:0]   aes_dout;
    logic         aes_dok;
    logic [127:0] ct_data;
    logic         ct_valid;
    logic         ct_ready;
    logic         busy;
    logic         err;
    logic [1:0]   err_code;

    // master is the driver itself; slave is the host plus engine around it
    modport master (
        input  req_valid, req_pt, req_key, req_key_load,
        input  aes_ready, aes_dout, aes_dok, ct_ready,
        output req_ready, aes_cmd, aes_din, ct_data, ct_valid,
        output busy, err, err_code
    );

    modport slave (
        output req_valid, req_pt, req_key, req_key_load,
        output aes_ready, aes_dout, aes_dok, ct_ready,
        input  req_ready, aes_cmd, aes_din, ct_data, ct_valid,
        input  busy, err, err_code
    );
endinterface

// File: rtl/aes_host_driver.sv
// aes_host_driver: serializes a 128-bit plaintext (and optional key) onto the
// AES engine byte bus, starts it, and gathers the 16-byte ciphertext burst.
module aes_host_driver #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_,
    aes_host_driver_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_PT,
        ST_SEND_KEY,
        ST_START,
        ST_COLLECT,
        ST_DRAIN
    } state_e;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e       state_q, state_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] key_q, key_d;
    logic         key_load_q, key_load_d;
    logic [3:0]   idx_q, idx_d;
    logic [15:0]  tmo_q, tmo_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [127:0] shreg_q, shreg_d;
    logic [127:0] ct_data_q, ct_data_d;
    logic         ct_valid_q, ct_valid_d;
    logic         err_q, err_d;
    logic [1:0]   err_code_q, err_code_d;
    logic         req_ready;
    logic [1:0]   aes_cmd;
    logic [7:0]   aes_din;

    // A pending ciphertext blocks new work so it can never be overwritten
    assign req_ready = (state_q == ST_IDLE) && bus.aes_ready && !ct_valid_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= ST_IDLE;
            pt_q       <= '0;
            key_q      <= '0;
            key_load_q <= 1'b0;
            idx_q      <= '0;
            tmo_q      <= '0;
            cnt_q      <= '0;
            shreg_q    <= '0;
            ct_data_q  <= '0;
            ct_valid_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            pt_q       <= pt_d;
            key_q      <= key_d;
            key_load_q <= key_load_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            ct_data_q  <= ct_data_d;
            ct_valid_q <= ct_valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pt_d       = pt_q;
        key_d      = key_q;
        key_load_d = key_load_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        ct_data_d  = ct_data_q;
        ct_valid_d = ct_valid_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        if (ct_valid_q && bus.ct_ready) begin
            ct_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready) begin
                    pt_d       = bus.req_pt;
                    key_d      = bus.req_key;
                    key_load_d = bus.req_key_load;
                    idx_d      = '0;
                    state_d    = ST_SEND_PT;
                end
            end
            ST_SEND_PT: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    tmo_d   = '0;
                    state_d = key_load_q ? ST_SEND_KEY : ST_START;
                end
            end
            ST_SEND_KEY: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    tmo_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bus.aes_dok) begin
                    shreg_d = {shreg_q[119:0], bus.aes_dout};
                    cnt_d   = 5'd1;
                    state_d = ST_COLLECT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                    tmo_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_COLLECT: begin
                if (bus.aes_dok) begin
                    if (cnt_q == 5'd16) begin
                        err_d      = 1'b1;
                        err_code_d = 2'b11;
                        state_d    = ST_DRAIN;
                    end else begin
                        shreg_d = {shreg_q[119:0], bus.aes_dout};
                        cnt_d   = cnt_q + 5'd1;
                    end
                end else if (cnt_q == 5'd16) begin
                    ct_data_d  = shreg_q;
                    ct_valid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Overflow bytes are swallowed until the engine ends its burst
                if (!bus.aes_dok) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // idx counts bytes MSB-first, so ~idx selects byte lane 15-idx
    always_comb begin
        aes_cmd = 2'b00;
        aes_din = 8'h00;
        case (state_q)
            ST_SEND_PT: begin
                aes_cmd = 2'b01;
                aes_din = pt_q[{~idx_q, 3'b000} +: 8];
            end
            ST_SEND_KEY: begin
                aes_cmd = 2'b10;
                aes_din = key_q[{~idx_q, 3'b000} +: 8];
            end
            ST_START: aes_cmd = 2'b11;
            default: begin
                aes_cmd = 2'b00;
                aes_din = 8'h00;
            end
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.aes_cmd   = aes_cmd;
    assign bus.aes_din   = aes_din;
    assign bus.ct_data   = ct_data_q;
    assign bus.ct_valid  = ct_valid_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_aes_host_driver.sv
// tb_aes_host_driver: drives host requests and a behavioural byte-serial engine,
// comparing the command stream and results against transaction-level expectations.
module tb_aes_host_driver;
    localparam int TMO = 8;
    localparam logic [127:0] PLAN_PT  = 128'h00041214_12041200_0C001311_08231919;
    localparam logic [127:0] PLAN_KEY = 128'h2475A2B3_34755688_31E21200_13AA5487;
    localparam logic [127:0] PLAN_CT  = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;

    logic clk  = 1'b0;
    logic rst_ = 1'b0;
    int   check_count = 0;
    int   pass_count  = 0;
    int   fail_count  = 0;

    aes_host_driver_if bus ();

    aes_host_driver #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present a request and hold it until the accepting edge has passed
    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] key,
                                 input logic kl);
        int waited;
        waited = 0;
        bus.req_pt       = pt;
        bus.req_key      = key;
        bus.req_key_load = kl;
        bus.req_valid    = 1'b1;
        while (bus.req_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        checkOutput("accept_ready", 128'(bus.req_ready), 128'(1'b1));
        tick();
        bus.req_valid = 1'b0;
    endtask

    // nbytes==0 means the engine never answers
    task automatic runTransaction(input logic [127:0] pt, input logic [127:0] key,
                                  input logic kl, input int lat, input int nbytes,
                                  input logic seq_bytes);
        int           n01, n10, nother, n11, guard;
        logic [127:0] pt_seen, key_seen, ct_model;
        logic [7:0]   b;
        n01 = 0; n10 = 0; nother = 0; n11 = 0; guard = 0;
        pt_seen = '0; key_seen = '0; ct_model = '0;

        applyStimulus(pt, key, kl);
        while (bus.aes_cmd !== 2'b11 && guard < 64) begin
            case (bus.aes_cmd)
                2'b01: begin pt_seen  = {pt_seen[119:0],  bus.aes_din}; n01++; end
                2'b10: begin key_seen = {key_seen[119:0], bus.aes_din}; n10++; end
                default: nother++;
            endcase
            guard++;
            tick();
        end
        checkOutput("pt_cycles", 128'(n01), 128'(16));
        checkOutput("pt_bytes", pt_seen, pt);
        checkOutput("key_cycles", 128'(n10), kl ? 128'(16) : 128'(0));
        checkOutput("key_bytes", key_seen, kl ? key : 128'(0));
        checkOutput("phase_gaps", 128'(nother), 128'(0));
        checkOutput("start_cmd", 128'(bus.aes_cmd), 128'(2'b11));

        if (nbytes == 0) begin
            while (bus.aes_cmd === 2'b11 && n11 < 64) begin
                n11++;
                tick();
            end
            checkOutput("timeout_cycles", 128'(n11), 128'(TMO));
            checkOutput("timeout_err", 128'(bus.err), 128'(1'b1));
            checkOutput("timeout_code", 128'(bus.err_code), 128'(2'b01));
            checkOutput("timeout_busy", 128'(bus.busy), 128'(1'b0));
            checkOutput("timeout_ct_valid", 128'(bus.ct_valid), 128'(1'b0));
            tick();
            checkOutput("timeout_err_pulse", 128'(bus.err), 128'(1'b0));
        end else begin
            for (int i = 0; i < lat; i++) begin
                if (bus.aes_cmd === 2'b11) n11++;
                tick();
            end
            if (bus.aes_cmd === 2'b11) n11++;
            checkOutput("start_before_dok", 128'(n11), 128'(lat + 1));
            for (int i = 0; i < nbytes; i++) begin
                b = seq_bytes ? 8'(8'hB0 + i) : 8'($urandom);
                if (i < 16) ct_model = ct_model | (128'(b) << (8 * (15 - i)));
                bus.aes_dok  = 1'b1;
                bus.aes_dout = b;
                tick();
                if (i == 0) checkOutput("collect_cmd", 128'(bus.aes_cmd), 128'(2'b00));
                if (i == 16) begin
                    checkOutput("ovf_err", 128'(bus.err), 128'(1'b1));
                    checkOutput("ovf_code", 128'(bus.err_code), 128'(2'b11));
                end
            end
            if (nbytes > 16) checkOutput("drain_busy", 128'(bus.busy), 128'(1'b1));
            bus.aes_dok = 1'b0;
            tick();
            if (nbytes > 16) begin
                checkOutput("drain_done", 128'(bus.busy), 128'(1'b0));
                checkOutput("ovf_ct_valid", 128'(bus.ct_valid), 128'(1'b0));
            end else if (nbytes < 16) begin
                checkOutput("short_err", 128'(bus.err), 128'(1'b1));
                checkOutput("short_code", 128'(bus.err_code), 128'(2'b10));
                checkOutput("short_ct_valid", 128'(bus.ct_valid), 128'(1'b0));
                checkOutput("short_busy", 128'(bus.busy), 128'(1'b0));
            end else begin
                checkOutput("ct_valid", 128'(bus.ct_valid), 128'(1'b1));
                checkOutput("ct_data", bus.ct_data, ct_model);
                checkOutput("ok_err", 128'(bus.err), 128'(1'b0));
                checkOutput("ok_busy", 128'(bus.busy), 128'(1'b0));
            end
        end
    endtask

    task automatic releaseResult();
        bus.ct_ready = 1'b1;
        tick();
        checkOutput("ct_release", 128'(bus.ct_valid), 128'(1'b0));
        bus.ct_ready = 1'b0;
    endtask

    initial begin
        int ready_seen, data_changed, idle_busy;
        logic [127:0] rpt, rkey;
        bus.req_valid    = 1'b0;
        bus.req_pt       = '0;
        bus.req_key      = '0;
        bus.req_key_load = 1'b0;
        bus.aes_ready    = 1'b1;
        bus.aes_dout     = 8'h00;
        bus.aes_dok      = 1'b0;
        bus.ct_ready     = 1'b0;

        #2;
        checkOutput("rst_cmd", 128'(bus.aes_cmd), 128'(2'b00));
        checkOutput("rst_din", 128'(bus.aes_din), 128'(8'h00));
        checkOutput("rst_ct_valid", 128'(bus.ct_valid), 128'(1'b0));
        checkOutput("rst_ct_data", bus.ct_data, 128'(0));
        checkOutput("rst_err", 128'(bus.err), 128'(1'b0));
        checkOutput("rst_err_code", 128'(bus.err_code), 128'(2'b00));
        checkOutput("rst_busy", 128'(bus.busy), 128'(1'b0));
        @(negedge clk);
        rst_ = 1'b1;
        tick();

        $display("[TB] full request with key");
        runTransaction(PLAN_PT, PLAN_KEY, 1'b1, 2, 16, 1'b1);

        $display("[TB] result held while host stalls");
        bus.req_pt       = PLAN_PT;
        bus.req_key      = PLAN_KEY;
        bus.req_key_load = 1'b0;
        bus.req_valid    = 1'b1;
        ready_seen = 0;
        data_changed = 0;
        repeat (20) begin
            tick();
            if (bus.req_ready !== 1'b0) ready_seen++;
            if (bus.ct_data !== PLAN_CT) data_changed++;
        end
        checkOutput("hold_req_ready", 128'(ready_seen), 128'(0));
        checkOutput("hold_ct_data", 128'(data_changed), 128'(0));
        checkOutput("hold_ct_valid", 128'(bus.ct_valid), 128'(1'b1));
        bus.ct_ready = 1'b1;
        tick();
        checkOutput("hold_release", 128'(bus.ct_valid), 128'(1'b0));
        checkOutput("hold_ready_after", 128'(bus.req_ready), 128'(1'b1));
        bus.ct_ready = 1'b0;

        $display("[TB] request reusing stored key");
        runTransaction(PLAN_PT, PLAN_KEY, 1'b0, int'($urandom_range(0, 5)), 16, 1'b0);
        releaseResult();

        $display("[TB] randomized requests");
        for (int t = 0; t < 4; t++) begin
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            rkey = {$urandom, $urandom, $urandom, $urandom};
            runTransaction(rpt, rkey, 1'($urandom), int'($urandom_range(0, 5)), 16, 1'b0);
            releaseResult();
        end

        $display("[TB] engine timeout");
        runTransaction(PLAN_PT, PLAN_KEY, 1'b0, 0, 0, 1'b0);

        $display("[TB] short burst");
        runTransaction({$urandom, $urandom, $urandom, $urandom}, PLAN_KEY, 1'b0, 1, 12, 1'b0);

        $display("[TB] overflow burst");
        runTransaction(PLAN_PT, PLAN_KEY, 1'b1, 3, 18, 1'b1);

        $display("[TB] stray data_ok and engine not ready while idle");
        idle_busy = 0;
        bus.aes_dok = 1'b1;
        repeat (3) begin
            tick();
            if (bus.busy !== 1'b0 || bus.err !== 1'b0) idle_busy++;
        end
        bus.aes_dok = 1'b0;
        checkOutput("idle_dok_ignored", 128'(idle_busy), 128'(0));
        bus.aes_ready = 1'b0;
        bus.req_valid = 1'b1;
        #1;
        checkOutput("not_ready_block", 128'(bus.req_ready), 128'(1'b0));
        tick();
        checkOutput("not_ready_idle", 128'(bus.busy), 128'(1'b0));
        bus.req_valid = 1'b0;
        bus.aes_ready = 1'b1;

        $display("[TB] asynchronous reset during key phase");
        applyStimulus(PLAN_PT, PLAN_KEY, 1'b1);
        repeat (20) tick();
        checkOutput("pre_reset_cmd", 128'(bus.aes_cmd), 128'(2'b10));
        #3;
        rst_ = 1'b0;
        #1;
        checkOutput("arst_cmd", 128'(bus.aes_cmd), 128'(2'b00));
        checkOutput("arst_din", 128'(bus.aes_din), 128'(8'h00));
        checkOutput("arst_busy", 128'(bus.busy), 128'(1'b0));
        checkOutput("arst_err_code", 128'(bus.err_code), 128'(2'b00));
        checkOutput("arst_ct_data", bus.ct_data, 128'(0));
        checkOutput("arst_ct_valid", 128'(bus.ct_valid), 128'(1'b0));
        @(negedge clk);
        rst_ = 1'b1;
        tick();

        $display("[TB] clean request after reset");
        runTransaction(PLAN_PT, PLAN_KEY, 1'b1, 4, 16, 1'b1);
        releaseResult();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
